alu_issue_stage: RTL and testbench

//  ID->EX issue register feeding the ALU. Decodes RV32I OP/OP-IMM/LUI/AUIPC into
//  the 4-bit ALU control code and selects and forwards operands. Holds one

---
 rtl/alu_pkg.sv | 82 ++++++++
 rtl/alu_op_decode.sv | 77 +++++++
 rtl/alu_issue_stage.sv | 153 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_pkg                                                                  |
// | Shared ALU control codes, RV32I opcode/funct constants and slot type.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_ZERO = 2'd0,
        OPA_RS1  = 2'd1,
        OPA_PC   = 2'd2
    } opa_sel_e;

    typedef enum logic [1:0] {
        OPB_ZERO = 2'd0,
        OPB_RS2  = 2'd1,
        OPB_IMM  = 2'd2
    } opb_sel_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_op_e           control;
        logic [4:0]        rd;
        logic              wen;
        logic [DATA_W-1:0] pc;
        logic              illegal;
    } issue_slot_t;

    // Operation selected by funct3 when funct7 is the base encoding.
    function automatic alu_op_e f3_base_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// +--------------------------------------------------------------------------+
// | alu_op_decode                                                            |
// | Combinational RV32I OP/OP-IMM/LUI/AUIPC decode to ALU control + selects. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    control,
    output opa_sel_e   sel_a,
    output opb_sel_e   sel_b,
    output logic       illegal
);

    always_comb begin
        control = ALU_ADD;
        sel_a   = OPA_ZERO;
        sel_b   = OPB_ZERO;
        illegal = 1'b0;

        case (opcode)
            OPC_OP: begin
                sel_a = OPA_RS1;
                sel_b = OPB_RS2;
                if (funct7 == F7_BASE) begin
                    control = f3_base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    control = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    control = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                sel_a = OPA_RS1;
                sel_b = OPB_IMM;
                // Only shifts constrain funct7; other immediates own those bits.
                if (funct3 == F3_SLL) begin
                    if (funct7 == F7_BASE) control = ALU_SLL;
                    else                   illegal = 1'b1;
                end else if (funct3 == F3_SR) begin
                    if (funct7 == F7_BASE)     control = ALU_SRL;
                    else if (funct7 == F7_ALT) control = ALU_SRA;
                    else                       illegal = 1'b1;
                end else begin
                    control = f3_base_op(funct3);
                end
            end
            OPC_LUI: begin
                sel_b = OPB_IMM;
            end
            OPC_AUIPC: begin
                sel_a = OPA_PC;
                sel_b = OPB_IMM;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        // Illegal slots carry a harmless ADD of zeros downstream.
        if (illegal) begin
            control = ALU_ADD;
            sel_a   = OPA_ZERO;
            sel_b   = OPB_ZERO;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// +--------------------------------------------------------------------------+
// | alu_issue_stage                                                          |
// | ID->EX issue slot: decode, operand forwarding, valid/ready, statistics.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_rs1_data,
    input  logic [XLEN-1:0]      in_rs2_data,
    input  logic                 fwd_ex_en,
    input  logic [4:0]           fwd_ex_rd,
    input  logic [XLEN-1:0]      fwd_ex_data,
    input  logic                 fwd_wb_en,
    input  logic [4:0]           fwd_wb_rd,
    input  logic [XLEN-1:0]      fwd_wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_a,
    output logic [XLEN-1:0]      out_b,
    output logic [3:0]           out_control,
    output logic [4:0]           out_rd,
    output logic                 out_wen,
    output logic [XLEN-1:0]      out_pc,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] stat_issued,
    output logic [CNT_WIDTH-1:0] stat_illegal
);

    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    alu_op_e         w_control;
    opa_sel_e        w_sel_a;
    opb_sel_e        w_sel_b;
    logic            w_illegal;
    issue_slot_t     w_next_slot;
    logic            w_capture;
    logic            w_consume;

    issue_slot_t     r_slot;
    logic            r_valid;
    logic [CNT_WIDTH-1:0] r_issued;
    logic [CNT_WIDTH-1:0] r_illegal_cnt;

    assign w_rs1 = in_instr[19:15];
    assign w_rs2 = in_instr[24:20];
    assign w_rd  = in_instr[11:7];

    alu_op_decode u_decode (
        .opcode  (in_instr[6:0]),
        .funct3  (in_instr[14:12]),
        .funct7  (in_instr[31:25]),
        .control (w_control),
        .sel_a   (w_sel_a),
        .sel_b   (w_sel_b),
        .illegal (w_illegal)
    );

    // EX result is younger than WB, so it takes precedence.
    always_comb begin
        w_rs1_val = in_rs1_data;
        if (w_rs1 == 5'd0)                        w_rs1_val = '0;
        else if (fwd_ex_en && fwd_ex_rd == w_rs1) w_rs1_val = fwd_ex_data;
        else if (fwd_wb_en && fwd_wb_rd == w_rs1) w_rs1_val = fwd_wb_data;
    end

    always_comb begin
        w_rs2_val = in_rs2_data;
        if (w_rs2 == 5'd0)                        w_rs2_val = '0;
        else if (fwd_ex_en && fwd_ex_rd == w_rs2) w_rs2_val = fwd_ex_data;
        else if (fwd_wb_en && fwd_wb_rd == w_rs2) w_rs2_val = fwd_wb_data;
    end

    always_comb begin
        w_next_slot         = '0;
        w_next_slot.control = w_control;
        w_next_slot.rd      = w_rd;
        w_next_slot.wen     = !w_illegal && (w_rd != 5'd0);
        w_next_slot.pc      = in_pc;
        w_next_slot.illegal = w_illegal;
        case (w_sel_a)
            OPA_RS1: w_next_slot.a = w_rs1_val;
            OPA_PC:  w_next_slot.a = in_pc;
            default: w_next_slot.a = '0;
        endcase
        case (w_sel_b)
            OPB_RS2: w_next_slot.b = w_rs2_val;
            OPB_IMM: w_next_slot.b = in_imm;
            default: w_next_slot.b = '0;
        endcase
    end

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;
    assign w_consume = r_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_slot  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_slot  <= w_next_slot;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    // A slot flushed while being consumed is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued      <= '0;
            r_illegal_cnt <= '0;
        end else if (w_consume && !flush) begin
            r_issued <= r_issued + CNT_WIDTH'(1);
            if (r_slot.illegal) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_a        = r_slot.a;
    assign out_b        = r_slot.b;
    assign out_control  = r_slot.control;
    assign out_rd       = r_slot.rd;
    assign out_wen      = r_slot.wen;
    assign out_pc       = r_slot.pc;
    assign out_illegal  = r_slot.illegal;
    assign stat_issued  = r_issued;
    assign stat_illegal = r_illegal_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// +--------------------------------------------------------------------------+
// | tb_alu_issue_stage                                                       |
// | Directed self-checking bench for alu_issue_stage.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [31:0] in_imm;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        fwd_ex_en;
    logic [4:0]  fwd_ex_rd;
    logic [31:0] fwd_ex_data;
    logic        fwd_wb_en;
    logic [4:0]  fwd_wb_rd;
    logic [31:0] fwd_wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_control;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [31:0] stat_issued;
    logic [31:0] stat_illegal;

    // Narrow-counter instance shares all inputs to exercise wrap-around.
    logic        n_in_ready;
    logic        n_out_valid;
    logic [31:0] n_out_a;
    logic [31:0] n_out_b;
    logic [3:0]  n_out_control;
    logic [4:0]  n_out_rd;
    logic        n_out_wen;
    logic [31:0] n_out_pc;
    logic        n_out_illegal;
    logic [2:0]  n_stat_issued;
    logic [2:0]  n_stat_illegal;

    int passed = 0;
    int total  = 0;

    alu_issue_stage #(.XLEN(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_imm(in_imm),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .fwd_ex_en(fwd_ex_en), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_control(out_control),
        .out_rd(out_rd), .out_wen(out_wen), .out_pc(out_pc),
        .out_illegal(out_illegal),
        .stat_issued(stat_issued), .stat_illegal(stat_illegal)
    );

    alu_issue_stage #(.XLEN(32), .CNT_WIDTH(3)) dut_narrow (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_imm(in_imm),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .fwd_ex_en(fwd_ex_en), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_a(n_out_a), .out_b(n_out_b), .out_control(n_out_control),
        .out_rd(n_out_rd), .out_wen(n_out_wen), .out_pc(n_out_pc),
        .out_illegal(n_out_illegal),
        .stat_issued(n_stat_issued), .stat_illegal(n_stat_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_instr = 32'h0; in_imm = 32'h0;
        in_rs1_data = 32'h0; in_rs2_data = 32'h0;
        fwd_ex_en = 1'b0; fwd_ex_rd = 5'd0; fwd_ex_data = 32'h0;
        fwd_wb_en = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'h0;
        flush = 1'b0; out_ready = 1'b1;

        step();
        step();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_stat_issued", stat_issued, 32'd0);
        check("reset_out_a", out_a, 32'd0);
        rst_n = 1'b1;

        // ADD x3, x1, x2
        in_valid = 1'b1; in_pc = 32'h40;
        in_instr = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
        in_rs1_data = 32'd5; in_rs2_data = 32'd7;
        step();
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_a", out_a, 32'd5);
        check("add_b", out_b, 32'd7);
        check("add_control", {28'd0, out_control}, 32'd0);
        check("add_rd", {27'd0, out_rd}, 32'd3);
        check("add_wen", {31'd0, out_wen}, 32'd1);
        check("add_pc", out_pc, 32'h40);

        // SUB x5, x4, x6 with both EX and WB hitting x4
        in_instr = rtype(7'h20, 5'd6, 5'd4, 3'b000, 5'd5, 7'b0110011);
        in_rs1_data = 32'd1; in_rs2_data = 32'd9;
        fwd_ex_en = 1'b1; fwd_ex_rd = 5'd4; fwd_ex_data = 32'h10;
        fwd_wb_en = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'h20;
        step();
        check("fwd_ex_a", out_a, 32'h10);
        check("fwd_ex_b", out_b, 32'd9);
        check("sub_control", {28'd0, out_control}, 32'd1);
        check("issued_after_add", stat_issued, 32'd1);

        fwd_ex_en = 1'b0;
        step();
        check("fwd_wb_a", out_a, 32'h20);

        // SUB x5, x0, x6 with forwarding sources targeting x0
        in_instr = rtype(7'h20, 5'd6, 5'd0, 3'b000, 5'd5, 7'b0110011);
        fwd_ex_en = 1'b1; fwd_ex_rd = 5'd0; fwd_wb_rd = 5'd0;
        step();
        check("fwd_x0_a", out_a, 32'd0);
        check("issued_3", stat_issued, 32'd3);
        fwd_ex_en = 1'b0; fwd_wb_en = 1'b0;

        // Stall three cycles with a new instruction waiting
        out_ready = 1'b0;
        in_instr = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011);
        in_rs1_data = 32'd11; in_rs2_data = 32'd22;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_a", out_a, 32'd0);
            check("stall_b", out_b, 32'd9);
            check("stall_rd", {27'd0, out_rd}, 32'd5);
        end
        check("stall_issued", stat_issued, 32'd3);

        // Flush coinciding with consume
        flush = 1'b1; out_ready = 1'b1;
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_issued", stat_issued, 32'd3);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // SRAI x8, x1, 3
        in_valid = 1'b1; in_rs1_data = 32'h80;
        in_instr = rtype(7'h20, 5'd3, 5'd1, 3'b101, 5'd8, 7'b0010011);
        in_imm = 32'h0000_0403;
        step();
        check("srai_control", {28'd0, out_control}, 32'd9);
        check("srai_b", out_b, 32'h403);
        check("srai_a", out_a, 32'h80);
        check("srai_illegal", {31'd0, out_illegal}, 32'd0);

        // SLLI with funct7=0x20 is not a valid encoding
        in_instr = rtype(7'h20, 5'd3, 5'd1, 3'b001, 5'd9, 7'b0010011);
        step();
        check("slli_bad_illegal", {31'd0, out_illegal}, 32'd1);
        check("slli_bad_wen", {31'd0, out_wen}, 32'd0);
        check("slli_bad_control", {28'd0, out_control}, 32'd0);

        // LUI x10, 0xABCDE
        in_instr = {20'hABCDE, 5'd10, 7'b0110111};
        in_imm = 32'hABCD_E000;
        step();
        check("lui_a", out_a, 32'd0);
        check("lui_b", out_b, 32'hABCD_E000);
        check("lui_wen", {31'd0, out_wen}, 32'd1);
        check("illegal_cnt_1", stat_illegal, 32'd1);

        // AUIPC x11, 0x1 at pc 0x100
        in_instr = {20'h00001, 5'd11, 7'b0010111};
        in_imm = 32'h0000_1000; in_pc = 32'h100;
        step();
        check("auipc_a", out_a, 32'h100);
        check("auipc_b", out_b, 32'h1000);
        check("auipc_control", {28'd0, out_control}, 32'd0);

        // Branch opcode is not handled here
        in_instr = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd4, 7'b1100011);
        step();
        check("branch_illegal", {31'd0, out_illegal}, 32'd1);
        check("branch_wen", {31'd0, out_wen}, 32'd0);
        check("branch_a", out_a, 32'd0);
        check("branch_b", out_b, 32'd0);
        check("issued_7", stat_issued, 32'd7);

        // Eight back-to-back ADDs
        for (int i = 0; i < 8; i++) begin
            in_instr = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'(i + 1), 7'b0110011);
            in_rs1_data = 32'(i * 3);
            step();
            check("tput_in_ready", {31'd0, in_ready}, 32'd1);
            check("tput_valid", {31'd0, out_valid}, 32'd1);
            check("tput_rd", {27'd0, out_rd}, 32'(i + 1));
            check("tput_a", out_a, 32'(i * 3));
        end
        check("issued_15", stat_issued, 32'd15);
        check("narrow_all_ones", {29'd0, n_stat_issued}, 32'd7);
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("issued_16", stat_issued, 32'd16);
        check("narrow_wrap", {29'd0, n_stat_issued}, 32'd0);
        check("illegal_cnt_2", stat_illegal, 32'd2);

        // Async reset while stalled, away from any clock edge
        in_valid = 1'b1; out_ready = 1'b0;
        in_instr = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
        step();
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_issued", stat_issued, 32'd0);
        check("async_reset_illegal", stat_illegal, 32'd0);
        check("async_reset_a", out_a, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
